vin_cfa_mixer: RTL and testbench

Parametrised successor to the fixed mono/DES/RGBW input colour mixer. Converts N pixels per clock of RGB video into per-subpixel grey levels for any colour-filter-array (CFA) panel, using a runtime-programmable channel-select table of up to CFA_MAX x CFA_MAX entries. A mono (luma) mode is also provided. Sits between the video input receiver and the frame-buffer writer; mode and pattern changes take effect only at frame boundaries.

---
 rtl/vin_pkg.sv | 18 +
 rtl/vin_px_select.sv | 37 +++
 rtl/vin_cfa_mixer.sv | 144 ++++++++++++++
 tb/tb_vin_cfa_mixer.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vin_pkg.sv
// Shared select and mode codes for the input colour mixer.
package vin_pkg;

    typedef enum logic [2:0] {
        SEL_R    = 3'd0,
        SEL_G    = 3'd1,
        SEL_B    = 3'd2,
        SEL_W    = 3'd3,
        SEL_Y    = 3'd4,
        SEL_ZERO = 3'd5
    } sel_e;

    typedef enum logic {
        MODE_MONO = 1'b0,
        MODE_CFA  = 1'b1
    } mode_e;

endpackage

// File: rtl/vin_px_select.sv
// Per-pixel channel selector: picks R, G, B, min(RGB), luma or zero.
module vin_px_select
    import vin_pkg::*;
#(
    parameter int IN_BITS = 8
) (
    input  logic [IN_BITS-1:0] r,
    input  logic [IN_BITS-1:0] g,
    input  logic [IN_BITS-1:0] b,
    input  logic [2:0]         sel,
    output logic [IN_BITS-1:0] value
);

    logic [IN_BITS+3:0] luma_sum;
    logic [IN_BITS-1:0] luma;
    logic [IN_BITS-1:0] wmin;

    // Luma as 5R+9G+2B over 16 (shift-add), white as min(R,G,B), then select.
    always_comb begin
        luma_sum = ({4'b0, r} << 2) + {4'b0, r}
                 + ({4'b0, g} << 3) + {4'b0, g}
                 + ({4'b0, b} << 1);
        luma = luma_sum[IN_BITS+3:4];
        wmin = r;
        if (g < wmin) wmin = g;
        if (b < wmin) wmin = b;
        case (sel)
            SEL_R:   value = r;
            SEL_G:   value = g;
            SEL_B:   value = b;
            SEL_W:   value = wmin;
            SEL_Y:   value = luma;
            default: value = '0;  // SEL_ZERO and the unused codes 6, 7
        endcase
    end

endmodule

// File: rtl/vin_cfa_mixer.sv
// RGB to per-subpixel grey converter for arbitrary CFA panels, PPC pixels per beat.
module vin_cfa_mixer
    import vin_pkg::*;
#(
    parameter int PPC      = 2,
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 8,
    parameter int CFA_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_mode,
    input  logic [$clog2(CFA_MAX)-1:0]    cfg_period_x,
    input  logic [$clog2(CFA_MAX)-1:0]    cfg_period_y,
    input  logic                          cfg_lut_we,
    input  logic [2*$clog2(CFA_MAX)-1:0]  cfg_lut_addr,
    input  logic [2:0]                    cfg_lut_data,
    input  logic                          in_vsync,
    input  logic                          in_hsync,
    input  logic [3*IN_BITS*PPC-1:0]      in_color,
    input  logic                          in_valid,
    output logic [OUT_BITS*PPC-1:0]       out_color,
    output logic                          out_valid
);

    localparam int PW        = $clog2(CFA_MAX);
    localparam int LUT_DEPTH = 1 << (2 * PW);
    localparam int PX_IN     = 3 * IN_BITS;

    logic               hs_last;
    logic               hs_rise;
    logic               line_seen;
    logic [PW-1:0]      x_phase;
    logic [PW-1:0]      y_phase;
    logic [PW-1:0]      period_x;
    logic [PW-1:0]      period_y;
    mode_e              mode;
    logic [2:0]         lut [LUT_DEPTH];
    logic [IN_BITS-1:0] sel_val [PPC];
    logic [IN_BITS-1:0] raw_p1 [PPC];
    logic               vld_p1;
    logic               vld_p2;

    // Phase advance modulo the active period (period is stored minus one).
    function automatic logic [PW-1:0] phase_wrap(input logic [PW-1:0] base,
                                                 input int unsigned   inc,
                                                 input logic [PW-1:0] per);
        int unsigned sum;
        sum = 32'(base) + inc;
        return PW'(sum % (32'(per) + 32'd1));
    endfunction

    // Width conversion: replicate MSBs when widening, drop LSBs when narrowing.
    function automatic logic [OUT_BITS-1:0] width_conv(input logic [IN_BITS-1:0] v);
        logic [OUT_BITS-1:0] o;
        for (int i = 0; i < OUT_BITS; i++)
            o[i] = v[IN_BITS-1-((OUT_BITS-1-i) % IN_BITS)];
        return o;
    endfunction

    assign hs_rise = in_hsync & ~hs_last;

    for (genvar k = 0; k < PPC; k++) begin : g_px
        logic [PW-1:0] xk;
        logic [2:0]    sel;

        // Column phase of this slot and its table entry; MONO forces luma.
        always_comb begin
            xk  = phase_wrap(x_phase, k, period_x);
            sel = (mode == MODE_MONO) ? 3'(SEL_Y) : lut[{y_phase, xk}];
        end

        vin_px_select #(.IN_BITS(IN_BITS)) u_sel (
            .r     (in_color[(PPC-1-k)*PX_IN + 2*IN_BITS +: IN_BITS]),
            .g     (in_color[(PPC-1-k)*PX_IN +   IN_BITS +: IN_BITS]),
            .b     (in_color[(PPC-1-k)*PX_IN             +: IN_BITS]),
            .sel   (sel),
            .value (sel_val[k])
        );
    end

    // Sync edge tracking, x/y phase counters and frame-boundary config shadowing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_last   <= 1'b0;
            line_seen <= 1'b0;
            x_phase   <= '0;
            y_phase   <= '0;
            period_x  <= '0;
            period_y  <= '0;
            mode      <= MODE_MONO;
        end else begin
            hs_last <= in_hsync;
            if (hs_rise) begin
                x_phase   <= '0;
                line_seen <= 1'b0;
                if (in_vsync) begin
                    y_phase  <= '0;
                    mode     <= mode_e'(cfg_mode);
                    period_x <= cfg_period_x;
                    period_y <= cfg_period_y;
                end else if (line_seen) begin
                    // blank lines leave y alone
                    y_phase <= (y_phase == period_y) ? '0 : y_phase + 1'b1;
                end
            end else if (in_valid) begin
                x_phase   <= phase_wrap(x_phase, PPC, period_x);
                line_seen <= 1'b1;
            end
        end
    end

    // Channel-select table; new entries are visible from the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= SEL_Y;
        end else if (cfg_lut_we) begin
            lut[cfg_lut_addr] <= cfg_lut_data;
        end
    end

    // Two-stage pipeline; data registers hold their value between valid beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_color <= '0;
            for (int k = 0; k < PPC; k++) raw_p1[k] <= '0;
        end else begin
            // stage 1: selected raw channel value per pixel
            vld_p1 <= in_valid;
            if (in_valid)
                for (int k = 0; k < PPC; k++) raw_p1[k] <= sel_val[k];
            // stage 2: width-converted output
            vld_p2 <= vld_p1;
            if (vld_p1)
                for (int k = 0; k < PPC; k++)
                    out_color[(PPC-1-k)*OUT_BITS +: OUT_BITS] <= width_conv(raw_p1[k]);
        end
    end

    assign out_valid = vld_p2;

endmodule

// File: tb/tb_vin_cfa_mixer.sv
// Self-checking bench for vin_cfa_mixer against a line/column counting model.
module tb_vin_cfa_mixer;

    localparam int PPC      = 2;
    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 8;
    localparam int CFA_MAX  = 4;
    localparam int PW       = 2;
    localparam int OW       = OUT_BITS * PPC;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     cfg_mode = 1'b0;
    logic [PW-1:0]            cfg_period_x = '0;
    logic [PW-1:0]            cfg_period_y = '0;
    logic                     cfg_lut_we = 1'b0;
    logic [2*PW-1:0]          cfg_lut_addr = '0;
    logic [2:0]               cfg_lut_data = '0;
    logic                     in_vsync = 1'b0;
    logic                     in_hsync = 1'b0;
    logic [3*IN_BITS*PPC-1:0] in_color = '0;
    logic                     in_valid = 1'b0;
    logic [OW-1:0]            out_color;
    logic                     out_valid;

    vin_cfa_mixer #(.PPC(PPC), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .CFA_MAX(CFA_MAX)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
        .cfg_period_x(cfg_period_x), .cfg_period_y(cfg_period_y),
        .cfg_lut_we(cfg_lut_we), .cfg_lut_addr(cfg_lut_addr), .cfg_lut_data(cfg_lut_data),
        .in_vsync(in_vsync), .in_hsync(in_hsync), .in_color(in_color), .in_valid(in_valid),
        .out_color(out_color), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state: column count in line, data-line count in frame
    int          m_mode, m_px, m_py, m_col, m_dl;
    bit          m_had, m_hs_last;
    int          m_lut [16];
    bit          s1v, s2v;
    logic [OW-1:0] s1c, s2c;
    bit          exp_valid;
    logic [OW-1:0] exp_color;

    function automatic int luma(int r, int g, int b);
        return (5 * r + 9 * g + 2 * b) / 16;
    endfunction

    function automatic int chan(int sel, int r, int g, int b);
        int m;
        m = r;
        if (g < m) m = g;
        if (b < m) m = b;
        case (sel)
            0: return r;
            1: return g;
            2: return b;
            3: return m;
            4: return luma(r, g, b);
            default: return 0;
        endcase
    endfunction

    function automatic int conv(int v);
        longint acc;
        int nb;
        acc = v;
        nb  = IN_BITS;
        while (nb < OUT_BITS) begin
            acc = (acc << IN_BITS) | v;
            nb += IN_BITS;
        end
        return int'(acc >> (nb - OUT_BITS));
    endfunction

    function automatic logic [OW-1:0] model_beat();
        logic [OW-1:0] c;
        int r, g, b, xk, yk, sel;
        c = '0;
        for (int k = 0; k < PPC; k++) begin
            r  = int'(in_color[(PPC-1-k)*24 + 16 +: 8]);
            g  = int'(in_color[(PPC-1-k)*24 + 8  +: 8]);
            b  = int'(in_color[(PPC-1-k)*24      +: 8]);
            xk = (m_col + k) % (m_px + 1);
            yk = m_dl % (m_py + 1);
            sel = (m_mode == 0) ? 4 : m_lut[yk * 4 + xk];
            c[(PPC-1-k)*OUT_BITS +: OUT_BITS] = OUT_BITS'(conv(chan(sel, r, g, b)));
        end
        return c;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_px = 0; m_py = 0; m_col = 0; m_dl = 0;
        m_had = 0; m_hs_last = 0;
        for (int i = 0; i < 16; i++) m_lut[i] = 4;
        s1v = 0; s2v = 0; s1c = '0; s2c = '0;
        exp_valid = 0; exp_color = '0;
    endtask

    task automatic model_edge();
        bit hs_rise;
        logic [OW-1:0] nc;
        hs_rise = in_hsync && !m_hs_last;
        nc = in_valid ? model_beat() : '0;
        s2v = s1v; s2c = s1c;
        s1v = in_valid; s1c = nc;
        exp_valid = s2v;
        if (s2v) exp_color = s2c;
        if (hs_rise) begin
            m_col = 0;
            if (in_vsync) begin
                m_dl = 0;
                m_mode = int'(cfg_mode);
                m_px = int'(cfg_period_x);
                m_py = int'(cfg_period_y);
            end else if (m_had) begin
                m_dl++;
            end
            m_had = 0;
        end else if (in_valid) begin
            m_col += PPC;
            m_had = 1;
        end
        if (cfg_lut_we) m_lut[cfg_lut_addr] = int'(cfg_lut_data);
        m_hs_last = in_hsync;
    endtask

    // one clock: model consumes current inputs, then DUT edge, then settle
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(int k, int r, int g, int b);
        in_color[(PPC-1-k)*24 +: 24] = {8'(r), 8'(g), 8'(b)};
    endtask

    task automatic hs_line(bit vs);
        in_valid = 0; in_hsync = 1; in_vsync = vs;
        cyc();
        in_hsync = 0; in_vsync = 0;
        cyc();
    endtask

    task automatic lut_write(int addr, int data);
        cfg_lut_we = 1; cfg_lut_addr = 4'(addr); cfg_lut_data = 3'(data);
        cyc();
        cfg_lut_we = 0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_color !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b c=%h, want v=0 c=0", out_valid, out_color);
        end
        rst = 0;
        repeat (3) begin
            cyc();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: got v=%0b, want v=0", out_valid);
            end
        end
    endtask

    task automatic test_mono();
        int seen;
        cfg_mode = 0;
        hs_line(1);
        hs_line(0);
        set_px(0, 255, 0, 0);
        set_px(1, 255, 255, 255);
        in_valid = 1;
        cyc();
        in_valid = 0;
        cyc();
        checks++;
        if (out_valid !== 1'b1 || out_color !== {8'd79, 8'd255}) begin
            errors++;
            $display("FAIL mono_const: got v=%0b c=%h, want v=1 c=4fff", out_valid, out_color);
        end
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            in_valid = (i < 20) && ($urandom_range(3) != 0);
            for (int k = 0; k < PPC; k++)
                set_px(k, $urandom_range(255), $urandom_range(255), $urandom_range(255));
            cyc();
            checks++;
            if (out_valid !== exp_valid || out_color !== exp_color) begin
                errors++;
                $display("FAIL mono_model: got v=%0b c=%h, want v=%0b c=%h",
                         out_valid, out_color, exp_valid, exp_color);
            end
        end
    endtask

    task automatic test_cfa_columns();
        logic [OW-1:0] want [3];
        int n;
        want[0] = {8'd10, 8'd30};
        want[1] = {8'd20, 8'd10};
        want[2] = {8'd30, 8'd20};
        lut_write(0, 0);
        lut_write(1, 2);
        lut_write(2, 1);
        cfg_mode = 1; cfg_period_x = 2; cfg_period_y = 0;
        hs_line(1);
        hs_line(0);
        set_px(0, 10, 20, 30);
        set_px(1, 10, 20, 30);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 3);
            cyc();
            checks++;
            if (out_valid !== exp_valid || out_color !== exp_color) begin
                errors++;
                $display("FAIL cfa_col_model: got v=%0b c=%h, want v=%0b c=%h",
                         out_valid, out_color, exp_valid, exp_color);
            end
            if (out_valid === 1'b1 && n < 3) begin
                checks++;
                if (out_color !== want[n]) begin
                    errors++;
                    $display("FAIL cfa_col_beat%0d: got %h, want %h", n, out_color, want[n]);
                end
                n++;
            end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL cfa_col_count: got %0d beats, want 3", n);
        end
    endtask

    task automatic test_cfa_rows();
        int want_first [5];
        int sel_rows [3][3];
        int got_first;
        bit first;
        want_first = '{10, 20, 30, 10, 20};
        sel_rows = '{'{0, 1, 2}, '{1, 2, 0}, '{2, 0, 1}};
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
                lut_write(y * 4 + x, sel_rows[y][x]);
        cfg_mode = 1; cfg_period_x = 2; cfg_period_y = 2;
        hs_line(1);
        for (int line = 0; line < 5; line++) begin
            if (line == 2) hs_line(0);  // blank line between data lines 1 and 2
            hs_line(0);
            first = 1;
            for (int i = 0; i < 5; i++) begin
                in_valid = (i < 2);
                if (i == 0) begin
                    set_px(0, 10, 20, 30);
                    set_px(1, 10, 20, 30);
                end else begin
                    for (int k = 0; k < PPC; k++)
                        set_px(k, $urandom_range(255), $urandom_range(255), $urandom_range(255));
                end
                cyc();
                checks++;
                if (out_valid !== exp_valid || out_color !== exp_color) begin
                    errors++;
                    $display("FAIL cfa_row_model: got v=%0b c=%h, want v=%0b c=%h",
                             out_valid, out_color, exp_valid, exp_color);
                end
                if (out_valid === 1'b1 && first) begin
                    first = 0;
                    got_first = int'(out_color[OW-1 -: OUT_BITS]);
                    checks++;
                    if (got_first != want_first[line]) begin
                        errors++;
                        $display("FAIL cfa_row_line%0d: got %0d, want %0d",
                                 line, got_first, want_first[line]);
                    end
                end
            end
        end
    endtask

    // sends one (40,25,60) beat on a fresh line and checks the result
    task automatic rgbw_line(bit vs_first, logic [OW-1:0] want, string tag);
        bit seen;
        if (vs_first) hs_line(1);
        hs_line(0);
        set_px(0, 40, 25, 60);
        set_px(1, 40, 25, 60);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 0);
            cyc();
            checks++;
            if (out_valid !== exp_valid || out_color !== exp_color) begin
                errors++;
                $display("FAIL %s_model: got v=%0b c=%h, want v=%0b c=%h",
                         tag, out_valid, out_color, exp_valid, exp_color);
            end
            if (out_valid === 1'b1) begin
                seen = 1;
                checks++;
                if (out_color !== want) begin
                    errors++;
                    $display("FAIL %s: got %h, want %h", tag, out_color, want);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: got no valid beat, want one", tag);
        end
    endtask

    task automatic test_rgbw();
        lut_write(0, 1);
        lut_write(1, 2);
        lut_write(4, 0);
        lut_write(5, 3);
        cfg_mode = 1; cfg_period_x = 1; cfg_period_y = 1;
        rgbw_line(1, {8'd25, 8'd60}, "rgbw_row0");
        rgbw_line(0, {8'd40, 8'd25}, "rgbw_row1");
    endtask

    task automatic test_mode_change();
        cfg_mode = 0;
        hs_line(1);
        cfg_mode = 1;  // pending until the next frame start
        rgbw_line(0, {8'd34, 8'd34}, "mode_hold0");
        rgbw_line(0, {8'd34, 8'd34}, "mode_hold1");
        rgbw_line(1, {8'd25, 8'd60}, "mode_switch");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            in_hsync = ($urandom_range(9) == 0);
            in_vsync = in_hsync && ($urandom_range(4) == 0);
            in_valid = ($urandom_range(9) < 7);
            cfg_mode = 1'($urandom_range(1));
            cfg_period_x = PW'($urandom_range(3));
            cfg_period_y = PW'($urandom_range(3));
            cfg_lut_we = ($urandom_range(7) == 0);
            cfg_lut_addr = 4'($urandom_range(15));
            cfg_lut_data = 3'($urandom_range(7));
            for (int k = 0; k < PPC; k++)
                set_px(k, $urandom_range(255), $urandom_range(255), $urandom_range(255));
            cyc();
            checks++;
            if (out_valid !== exp_valid || out_color !== exp_color) begin
                errors++;
                $display("FAIL random_model@%0d: got v=%0b c=%h, want v=%0b c=%h",
                         i, out_valid, out_color, exp_valid, exp_color);
            end
        end
        in_hsync = 0; in_vsync = 0; in_valid = 0; cfg_lut_we = 0;
    endtask

    task automatic test_reset_mid();
        cfg_mode = 1;
        hs_line(1);
        hs_line(0);
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < PPC; k++)
                set_px(k, $urandom_range(1, 255), $urandom_range(1, 255), $urandom_range(1, 255));
            cyc();
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: got v=%0b, want v=1", out_valid);
        end
        rst = 1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_color !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear: got v=%0b c=%h, want v=0 c=0", out_valid, out_color);
        end
        model_reset();
        @(posedge clk);
        #1;
        in_valid = 0;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (out_valid !== 1'b0 || out_color !== '0) begin
                errors++;
                $display("FAIL rst_mid_stale: got v=%0b c=%h, want v=0 c=0", out_valid, out_color);
            end
        end
        // after reset the mixer is MONO again
        set_px(0, 255, 0, 0);
        set_px(1, 255, 255, 255);
        in_valid = 1;
        cyc();
        in_valid = 0;
        cyc();
        checks++;
        if (out_valid !== 1'b1 || out_color !== {8'd79, 8'd255}) begin
            errors++;
            $display("FAIL rst_mid_after: got v=%0b c=%h, want v=1 c=4fff", out_valid, out_color);
        end
    endtask

    initial begin
        test_reset();
        test_mono();
        test_cfa_columns();
        test_cfa_rows();
        test_rgbw();
        test_mode_change();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
